// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
package shift_arb_pkg;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NREQ = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [AW-1:0] amt;
    logic          lr;
  } shift_req_t;

endpackage

// File: rtl/barrel_shifter_multi.sv
// 8-bit combinational rotating barrel shifter, log2 stages of 1/2/4 positions.
module barrel_shifter_multi
  import shift_arb_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [AW-1:0] amt_i,
  input  logic          lr_i,
  output logic [DW-1:0] y_o
);

  logic [DW-1:0] stage1;
  logic [DW-1:0] stage2;

  // lr_i = 1 rotates right, 0 rotates left; a 4-position rotate is direction-agnostic
  always_comb begin
    stage1 = a_i;
    if (amt_i[0]) stage1 = lr_i ? {a_i[0], a_i[7:1]} : {a_i[6:0], a_i[7]};
    stage2 = stage1;
    if (amt_i[1]) stage2 = lr_i ? {stage1[1:0], stage1[7:2]} : {stage1[5:0], stage1[7:6]};
    y_o = stage2;
    if (amt_i[2]) y_o = {stage2[3:0], stage2[7:4]};
  end

endmodule

// File: rtl/shift_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick: lone requester wins, contention favours ~last.
module rr_arb2
  import shift_arb_pkg::*;
(
  input  logic [NREQ-1:0] valid_i,
  input  logic            last_i,
  output logic            grant_o,
  output logic            any_o
);

  always_comb begin
    any_o   = |valid_i;
    grant_o = 1'b0;
    case (valid_i)
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin scheduler sharing one barrel shifter between two requesters.
// Optional grant counters are built when SHIFT_ARB_STATS_EN is defined.
module shift_arbiter
  import shift_arb_pkg::*;
`ifdef SHIFT_ARB_STATS_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][DW-1:0]   req_a,
  input  logic [NREQ-1:0][AW-1:0]   req_amt,
  input  logic [NREQ-1:0]           req_lr,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [DW-1:0]             rsp_y
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][CNT_W-1:0] grant_cnt
`endif
);

  state_t        state_q, state_d;
  shift_req_t    op_q;
  logic          owner_q;
  logic          lastGrant_q;
  logic [DW-1:0] rspY_q;
  logic [DW-1:0] shiftY;
  logic          grant;
  logic          anyValid;
  logic          reqFire;

  rr_arb2 u_arb (
    .valid_i (req_valid),
    .last_i  (lastGrant_q),
    .grant_o (grant),
    .any_o   (anyValid)
  );

  barrel_shifter_multi u_shift (
    .a_i   (op_q.a),
    .amt_i (op_q.amt),
    .lr_i  (op_q.lr),
    .y_o   (shiftY)
  );

  assign reqFire = |(req_valid & req_ready);
  assign rsp_y   = rspY_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (reqFire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready[owner_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && anyValid) req_ready[grant] = 1'b1;
    if (state_q == RESP)             rsp_valid[owner_q] = 1'b1;
  end

  // lastGrant resets to 1 so requester 0 wins the first contention
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= '0;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      rspY_q      <= '0;
    end else begin
      if (reqFire) begin
        op_q        <= {req_a[grant], req_amt[grant], req_lr[grant]};
        owner_q     <= grant;
        lastGrant_q <= grant;
      end
      if (state_q == EXEC) rspY_q <= shiftY;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] grantCnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grantCnt_q <= '0;
    end else if (reqFire && (grantCnt_q[grant] != {CNT_W{1'b1}})) begin
      grantCnt_q[grant] <= grantCnt_q[grant] + CNT_W'(1);
    end
  end

  assign grant_cnt = grantCnt_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter; counter checks run when SHIFT_ARB_STATS_EN is defined.
module tb_shift_arbiter;

  logic            clk;
  logic            reset;
  logic [1:0]      reqValid;
  logic [1:0]      reqReady;
  logic [1:0][7:0] reqA;
  logic [1:0][2:0] reqAmt;
  logic [1:0]      reqLr;
  logic [1:0]      rspValid;
  logic [1:0]      rspReady;
  logic [7:0]      rspY;

  int errors;
  int checks;

`ifdef SHIFT_ARB_STATS_EN
  logic [1:0][15:0] grantCnt;
  logic [1:0][1:0]  grantCntSat;
  logic [1:0]       satReqReady;
  logic [1:0]       satRspValid;
  logic [7:0]       satRspY;

  shift_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_amt(reqAmt), .req_lr(reqLr), .rsp_valid(rspValid),
    .rsp_ready(rspReady), .rsp_y(rspY), .grant_cnt(grantCnt)
  );

  shift_arbiter #(.CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(satReqReady),
    .req_a(reqA), .req_amt(reqAmt), .req_lr(reqLr), .rsp_valid(satRspValid),
    .rsp_ready(rspReady), .rsp_y(satRspY), .grant_cnt(grantCntSat)
  );
`else
  shift_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_amt(reqAmt), .req_lr(reqLr), .rsp_valid(rspValid),
    .rsp_ready(rspReady), .rsp_y(rspY)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [2:0] amt,
                               input logic lr);
    reqA[idx]   = a;
    reqAmt[idx] = amt;
    reqLr[idx]  = lr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [1:0] expMask;
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    reqValid = '0;
    rspReady = '0;
    reqA     = '0;
    reqAmt   = '0;
    reqLr    = '0;

    #3;
    checkOutput("reset_req_ready", 32'(reqReady), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("reset_rsp_y",     32'(rspY),     32'h0);
    step();
    step();
    reset = 1'b0;

    // single request on requester 0: rotate right by 1
    applyStimulus(0, 8'h01, 3'd1, 1'b1);
    reqValid = 2'b01;
    #1;
    checkOutput("t1_req_ready", 32'(reqReady), 32'h1);
    step();
    reqValid = 2'b00;
    checkOutput("t1_exec_rsp_valid", 32'(rspValid), 32'h0);
    step();
    checkOutput("t1_rsp_valid", 32'(rspValid), 32'h1);
    checkOutput("t1_rsp_y",     32'(rspY),     32'h80);
    rspReady = 2'b01;
    step();
    checkOutput("t1_back_idle", 32'(rspValid), 32'h0);
    rspReady = 2'b00;

    // requester 1 left rotate, non-owner ready must be ignored
    applyStimulus(1, 8'h2B, 3'd3, 1'b0);
    reqValid = 2'b10;
    #1;
    checkOutput("t2_req_ready", 32'(reqReady), 32'h2);
    step();
    reqValid = 2'b00;
    step();
    checkOutput("t2_rsp_valid", 32'(rspValid), 32'h2);
    checkOutput("t2_rsp_y",     32'(rspY),     32'h59);
    rspReady = 2'b01;
    step();
    checkOutput("t2_nonowner_ignored", 32'(rspValid), 32'h2);
    rspReady = 2'b10;
    step();
    checkOutput("t2_back_idle", 32'(rspValid), 32'h0);

    // requester 1 right rotate of the same operand
    applyStimulus(1, 8'h2B, 3'd3, 1'b1);
    reqValid = 2'b10;
    step();
    reqValid = 2'b00;
    step();
    checkOutput("t3_rsp_valid", 32'(rspValid), 32'h2);
    checkOutput("t3_rsp_y",     32'(rspY),     32'h65);
    step();
    checkOutput("t3_back_idle", 32'(rspValid), 32'h0);

    // contention after reset alternates 0,1,0,1
    reset = 1'b1;
    #1;
    reset = 1'b0;
    applyStimulus(0, 8'h2B, 3'd0, 1'b0);
    applyStimulus(1, 8'h01, 3'd7, 1'b0);
    reqValid = 2'b11;
    rspReady = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      expMask = 2'b01 << (k % 2);
      checkOutput("ct_req_ready", 32'(reqReady), 32'(expMask));
      step();
      step();
      checkOutput("ct_rsp_valid", 32'(rspValid), 32'(expMask));
      checkOutput("ct_rsp_y", 32'(rspY), (k % 2 == 1) ? 32'h80 : 32'h2B);
      if (k == 3) reqValid = 2'b00;
      step();
    end
    checkOutput("ct_idle", 32'(rspValid), 32'h0);

    // backpressure: response held for 5 cycles while requester 1 waits
    rspReady = 2'b00;
    applyStimulus(0, 8'h96, 3'd2, 1'b0);
    reqValid = 2'b01;
    step();
    reqValid = 2'b10;
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", 32'(rspValid), 32'h1);
      checkOutput("bp_rsp_y",     32'(rspY),     32'h5A);
      checkOutput("bp_req_ready", 32'(reqReady), 32'h0);
      step();
    end
    rspReady = 2'b01;
    step();
    checkOutput("bp_idle_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("bp_idle_req_ready", 32'(reqReady), 32'h2);
    reqValid = 2'b00;
    rspReady = 2'b00;

    // reset during EXEC discards the operation and restores the pointer
    applyStimulus(0, 8'hFF, 3'd1, 1'b0);
    reqValid = 2'b01;
    step();
    reqValid = 2'b00;
    checkOutput("mo_exec_rsp_y", 32'(rspY), 32'h5A);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mo_async_rsp_y",     32'(rspY),     32'h0);
    checkOutput("mo_async_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("mo_async_req_ready", 32'(reqReady), 32'h0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("mo_no_rsp", 32'(rspValid), 32'h0);
    end
    applyStimulus(0, 8'h81, 3'd4, 1'b1);
    applyStimulus(1, 8'h01, 3'd1, 1'b0);
    reqValid = 2'b11;
    #1;
    checkOutput("mo_grant0", 32'(reqReady), 32'h1);
    step();
    reqValid = 2'b00;
    step();
    checkOutput("mo_rsp_valid", 32'(rspValid), 32'h1);
    checkOutput("mo_rsp_y",     32'(rspY),     32'h18);
    rspReady = 2'b01;
    step();
    rspReady = 2'b00;

`ifdef SHIFT_ARB_STATS_EN
    // 5 grants to requester 0 and 3 to requester 1
    reset = 1'b1;
    #1;
    reset = 1'b0;
    checkOutput("st_reset_cnt0", 32'(grantCnt[0]), 32'h0);
    checkOutput("st_reset_cnt1", 32'(grantCnt[1]), 32'h0);
    rspReady = 2'b11;
    for (int k = 0; k < 8; k++) begin
      reqValid = (k < 6) ? (2'b01 << (k % 2)) : 2'b01;
      step();
      reqValid = 2'b00;
      step();
      step();
    end
    rspReady = 2'b00;
    checkOutput("st_cnt0",     32'(grantCnt[0]),    32'd5);
    checkOutput("st_cnt1",     32'(grantCnt[1]),    32'd3);
    checkOutput("st_sat_cnt0", 32'(grantCntSat[0]), 32'd3);
    checkOutput("st_sat_cnt1", 32'(grantCntSat[1]), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
